// File: rtl/wb_slave_mem32.sv
// 32-bit WISHBONE slave: word-addressed RAM with byte-lane writes, programmable wait states,
// busy-retry and (with WB_SLAVE_ERR_EN defined) address-decode error responses.
module wb_slave_mem32 #(
  parameter int          AW          = 8,
  parameter logic [31:0] BASE        = 32'h4000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [3:0]  SEL_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  TAG_I,
  input  logic        BUSY_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic        RTY_O,
  output logic [3:0]  TAG_O,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request is CYC_I&STB_I sampled in IDLE; it is answered by exactly one
  // single-cycle ACK_O, ERR_O or RTY_O, after which the slave spends one cycle in TERM.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_TERM = 2'd2
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          rty_q, rty_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    tag_q, tag_d;
  logic          access;
  logic          req;
  logic          hit;
  logic [AW-1:0] idx;
  logic [31:0]   mem [2**AW];

  assign req = CYC_I & STB_I;
  assign idx = ADR_I[AW+1:2];

`ifdef WB_SLAVE_ERR_EN
  assign hit   = (ADR_I[31:AW+2] == BASE[31:AW+2]);
  assign ERR_O = err_q;
  logic unused_bits;
  assign unused_bits = ^ADR_I[1:0];
`else
  // Without decode every address aliases into the RAM.
  assign hit   = 1'b1;
  assign ERR_O = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{ADR_I[1:0], ADR_I[31:AW+2], BASE, err_q};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rty_d   = 1'b0;
    dat_d   = dat_q;
    tag_d   = tag_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          tag_d = TAG_I;
          if (!hit) begin
            err_d   = 1'b1;
            state_d = S_TERM;
          end else if (BUSY_I) begin
            rty_d   = 1'b1;
            state_d = S_TERM;
          end else if (WS == 4'd0) begin
            access  = 1'b1;
            state_d = S_TERM;
          end else begin
            cnt_d   = WS;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A dropped strobe or cycle abandons the transfer silently.
        if (!req) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          access  = 1'b1;
          cnt_d   = 4'd0;
          state_d = S_TERM;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_TERM:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (access) begin
      ack_d = 1'b1;
      if (!WE_I) dat_d = mem[idx];
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      dat_q   <= 32'd0;
      tag_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      dat_q   <= dat_d;
      tag_q   <= tag_d;
    end
  end

  // RAM is not reset; an edge seen while reset is held must not write.
  always_ff @(posedge CLK_I) begin
    if (access && WE_I && !RST_I) begin
      for (int i = 0; i < 4; i++) begin
        if (SEL_I[i]) mem[idx][8*i +: 8] <= DAT_I[8*i +: 8];
      end
    end
  end

  assign DAT_O       = dat_q;
  assign ACK_O       = ack_q;
  assign RTY_O       = rty_q;
  assign TAG_O       = tag_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_slave_mem32.sv
// Bench for wb_slave_mem32: three instances (0, 1 and 3 wait states) driven with directed
// and randomized transfers, checked against a word-array memory model and a latency rule.
module tb_wb_slave_mem32;

  localparam logic [21:0] BASE_HI = 22'h10_0000;
`ifdef WB_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc [3];
  logic        stb [3];
  logic        we  [3];
  logic        busy[3];
  logic [31:0] adr [3];
  logic [31:0] dat_i[3];
  logic [31:0] dat_o[3];
  logic [3:0]  sel [3];
  logic [3:0]  tag_i[3];
  logic [3:0]  tag_o[3];
  logic        ack [3];
  logic        err [3];
  logic        rty [3];
  logic [1:0]  dbg [3];

  logic [31:0] mdl [3][256];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_slave_mem32 #(.WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3))) u_dut (
      .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[g]), .STB_I(stb[g]), .WE_I(we[g]),
      .ADR_I(adr[g]), .SEL_I(sel[g]), .DAT_I(dat_i[g]), .TAG_I(tag_i[g]), .BUSY_I(busy[g]),
      .DAT_O(dat_o[g]), .ACK_O(ack[g]), .ERR_O(err[g]), .RTY_O(rty[g]), .TAG_O(tag_o[g]),
      .dbg_state_o(dbg[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic logic [31:0] rand_adr(input int i);
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[31:10] = BASE_HI;
    a[9:2] = 8'(i);
    return a;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after a rising edge with the slave back in IDLE.
  task automatic xfer(input int d, input logic a_we, input logic [31:0] a_adr,
                      input logic [3:0] a_sel, input logic [31:0] a_dat, input logic [3:0] a_tag,
                      input logic a_busy, input logic hold_cyc, output logic [31:0] rdata);
    logic [2:0]  exp_kind, kind;
    logic [31:0] e;
    int          lat, exp_lat, i;
    i = int'(a_adr[9:2]);
    if (ERR_EN && a_adr[31:10] != BASE_HI) exp_kind = 3'b100;
    else if (a_busy)                       exp_kind = 3'b010;
    else                                   exp_kind = 3'b001;
    exp_lat = (exp_kind == 3'b001) ? ws_of(d) + 1 : 1;
    if (exp_kind == 3'b001 && !a_we) exp_q.push_back(mdl[d][i]);

    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = a_we; adr[d] = a_adr;
    sel[d] = a_sel; dat_i[d] = a_dat; tag_i[d] = a_tag; busy[d] = a_busy;
    kind = 3'b000;
    lat  = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ack[d] || err[d] || rty[d]) begin
        kind = {err[d], rty[d], ack[d]};
        lat  = n;
        break;
      end
    end
    rdata = dat_o[d];
    check($sformatf("kind d%0d", d), 32'(kind), 32'(exp_kind));
    check($sformatf("latency d%0d", d), 32'(lat), 32'(exp_lat));
    check($sformatf("tag d%0d", d), 32'(tag_o[d]), 32'(a_tag));
    if (exp_kind == 3'b001 && !a_we) begin
      e = exp_q.pop_front();
      check($sformatf("rdata d%0d idx%0d", d, i), rdata, e);
    end
    if (exp_kind == 3'b001 && a_we) begin
      for (int b = 0; b < 4; b++)
        if (a_sel[b]) mdl[d][i][8*b +: 8] = a_dat[8*b +: 8];
    end
    stb[d] = 1'b0;
    if (!hold_cyc) cyc[d] = 1'b0;
    @(posedge clk); #1;
    check($sformatf("pulse_clear d%0d", d), 32'({err[d], rty[d], ack[d]}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    int          seen;
    for (int d = 0; d < 3; d++) begin
      cyc[d] = 0; stb[d] = 0; we[d] = 0; busy[d] = 0;
      adr[d] = 0; dat_i[d] = 0; sel[d] = 0; tag_i[d] = 0;
    end
    #1 rst = 1'b1;
    #2;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset dat d%0d", d), dat_o[d], 32'd0);
      check($sformatf("reset ctl d%0d", d), 32'({ack[d], err[d], rty[d], tag_o[d]}), 32'd0);
      check($sformatf("reset state d%0d", d), 32'(dbg[d]), 32'd0);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Prefill the words the random phase uses so every read has a known value.
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 16; i++)
        xfer(d, 1'b1, 32'h4000_0000 + 32'(4 * i), 4'hF, $urandom, 4'(i), 1'b0, 1'b0, r);

    // Write then read back with tag echo (1 wait state).
    xfer(1, 1'b1, 32'h4000_0010, 4'hF, 32'hDEAD_BEEF, 4'h5, 1'b0, 1'b0, r);
    xfer(1, 1'b0, 32'h4000_0010, 4'hF, 32'h0, 4'h5, 1'b0, 1'b0, r);
    check("deadbeef const", r, 32'hDEAD_BEEF);

    // Byte-lane merge.
    xfer(1, 1'b1, 32'h4000_0014, 4'hF, 32'h1122_3344, 4'h1, 1'b0, 1'b0, r);
    xfer(1, 1'b1, 32'h4000_0014, 4'b0101, 32'hAABB_CCDD, 4'h2, 1'b0, 1'b0, r);
    xfer(1, 1'b0, 32'h4000_0014, 4'b0000, 32'h0, 4'h3, 1'b0, 1'b0, r);
    check("merge const", r, 32'h11BB_33DD);

    // Block read, zero wait states, CYC held between strobes.
    for (int i = 0; i < 4; i++)
      xfer(0, 1'b0, 32'h4000_0000 + 32'(4 * i), 4'hF, 32'h0, 4'(8 + i), 1'b0, 1'b1, r);
    cyc[0] = 1'b0;

    // Busy: retry termination leaves RAM untouched, then the retry succeeds.
    xfer(1, 1'b1, 32'h4000_0024, 4'hF, 32'hCAFE_F00D, 4'h7, 1'b1, 1'b0, r);
    xfer(1, 1'b0, 32'h4000_0024, 4'hF, 32'h0, 4'h7, 1'b0, 1'b0, r);
    xfer(1, 1'b1, 32'h4000_0024, 4'hF, 32'hCAFE_F00D, 4'h7, 1'b0, 1'b0, r);
    xfer(1, 1'b0, 32'h4000_0024, 4'hF, 32'h0, 4'h7, 1'b0, 1'b0, r);
    check("retry const", r, 32'hCAFE_F00D);

    // Out-of-window address: error with decode, alias of word 0 without.
    xfer(1, 1'b0, 32'h8000_0000, 4'hF, 32'h0, 4'hA, 1'b0, 1'b0, r);

    // Three wait states: strobe dropped after one cycle aborts silently.
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h4000_0020;
    sel[2] = 4'hF; dat_i[2] = 32'h0BAD_0BAD; tag_i[2] = 4'hC; busy[2] = 1'b0;
    @(posedge clk); #1;
    stb[2] = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[2] || err[2] || rty[2]) seen++;
    end
    check("abort no term", 32'(seen), 32'd0);
    check("abort state", 32'(dbg[2]), 32'd0);

    // Second write killed by reset mid-wait.
    stb[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("rst mid dat", dat_o[2], 32'd0);
    check("rst mid ctl", 32'({ack[2], err[2], rty[2], tag_o[2]}), 32'd0);
    check("rst mid state", 32'(dbg[2]), 32'd0);
    @(negedge clk); cyc[2] = 1'b0; stb[2] = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    xfer(2, 1'b0, 32'h4000_0020, 4'hF, 32'h0, 4'hD, 1'b0, 1'b0, r);

    // Randomized traffic, including read-modify-write on shared words.
    for (int t = 0; t < 180; t++) begin
      int d;
      d = $urandom_range(0, 2);
      xfer(d, 1'($urandom), rand_adr($urandom_range(0, 15)), 4'($urandom), $urandom,
           4'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom), r);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
